// File: rtl/ica_pkg.sv
// rtl/ica_pkg.sv - shared constants, state encoding and accumulator type for the g(u)*v^T accumulator
package ica_pkg;

    localparam int FRAC      = 14;
    localparam int N_SAMPLES = 64;
    localparam int ACC_W     = 40;
    localparam int U_W       = 32;
    localparam int Q_W       = 16;
    localparam int G_ONE     = 16384;
    localparam int CNT_W     = $clog2(N_SAMPLES);
    localparam int V_MAX     = 2 ** (Q_W - 1) - 1;
    localparam int V_MIN     = -(2 ** (Q_W - 1));

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } ica_state_e;

    typedef logic signed [ACC_W-1:0] acc_mat_t [0:2][0:2];

endpackage

// File: rtl/ica_hardtanh.sv
// rtl/ica_hardtanh.sv - Q28 to Q14 rescale with hard-tanh (g) and full-range (v) saturation
module ica_hardtanh
    import ica_pkg::*;
(
    input  logic signed [U_W-1:0] u_i,
    output logic signed [Q_W-1:0] g_o,
    output logic signed [Q_W-1:0] v_o
);

    localparam logic signed [U_W-1:0] V_HI = U_W'(V_MAX);
    localparam logic signed [U_W-1:0] V_LO = U_W'(V_MIN);
    localparam logic signed [U_W-1:0] G_HI = U_W'(G_ONE);
    localparam logic signed [U_W-1:0] G_LO = -U_W'(G_ONE);

    logic signed [U_W-1:0] sh;

    // Arithmetic shift floors toward minus infinity, so -1 in Q28 maps to -1 in Q14.
    assign sh = u_i >>> FRAC;

    always_comb begin
        v_o = sh[Q_W-1:0];
        g_o = sh[Q_W-1:0];
        if (sh > V_HI) begin
            v_o = V_HI[Q_W-1:0];
        end else if (sh < V_LO) begin
            v_o = V_LO[Q_W-1:0];
        end
        if (sh > G_HI) begin
            g_o = G_HI[Q_W-1:0];
        end else if (sh < G_LO) begin
            g_o = G_LO[Q_W-1:0];
        end
    end

endmodule

// File: rtl/ica_gu_accum.sv
// rtl/ica_gu_accum.sv - per-frame accumulation of G = sum g(u_k) v_k^T with valid/ready hand-off
module ica_gu_accum
    import ica_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [U_W-1:0] u_in [0:2],
    input  logic                 in_valid,
    output logic                 in_ready,
    output acc_mat_t             g_acc,
    output logic                 out_valid,
    input  logic                 out_ready
);

    ica_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic accept;
    logic clear;

    logic signed [Q_W-1:0] g_w  [0:2];
    logic signed [Q_W-1:0] v_w  [0:2];
    logic signed [Q_W-1:0] g1_q [0:2];
    logic signed [Q_W-1:0] v1_q [0:2];
    logic                  s1_valid_q;

    logic signed [2*Q_W-1:0] prod [0:2][0:2];
    acc_mat_t acc_q, acc_d;

    for (genvar i = 0; i < 3; i++) begin : g_lane
        ica_hardtanh u_ht (
            .u_i (u_in[i]),
            .g_o (g_w[i]),
            .v_o (v_w[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        clear     = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            // The only in-flight work is the stage-1 column; once it has landed G is final.
            DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                prod[i][j]  = 32'(g1_q[i]) * 32'(v1_q[j]);
                acc_d[i][j] = acc_q[i][j];
                if (clear) begin
                    acc_d[i][j] = '0;
                end else if (s1_valid_q) begin
                    acc_d[i][j] = acc_q[i][j]
                                + {{(ACC_W-2*Q_W){prod[i][j][2*Q_W-1]}}, prod[i][j]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                g1_q[i] <= '0;
                v1_q[i] <= '0;
                for (int j = 0; j < 3; j++) begin
                    acc_q[i][j] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= accept;
            for (int i = 0; i < 3; i++) begin
                if (accept) begin
                    g1_q[i] <= g_w[i];
                    v1_q[i] <= v_w[i];
                end
                for (int j = 0; j < 3; j++) begin
                    acc_q[i][j] <= acc_d[i][j];
                end
            end
        end
    end

    assign g_acc = acc_q;

endmodule

// File: tb/tb_ica_gu_accum.sv
// tb/tb_ica_gu_accum.sv - randomized frame bench for ica_gu_accum against an arithmetic model of G
module tb_ica_gu_accum;
    import ica_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [31:0]   u_in [0:2];
    logic                 in_valid;
    logic                 in_ready;
    acc_mat_t             g_acc;
    logic                 out_valid;
    logic                 out_ready;

    int total = 0;
    int bad   = 0;

    ica_gu_accum dut (
        .clk       (clk),
        .reset     (reset),
        .u_in      (u_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_acc     (g_acc),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint x, input longint lo, input longint hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // s = floor(u / 2^14) computed by integer division.
    function automatic longint q14(input longint u);
        if (u >= 0) return u / 16384;
        return -((-u + 16383) / 16384);
    endfunction

    task automatic gen_col(input int kind, output int col [3]);
        case (kind)
            0: begin col[0] = 1 << 28; col[1] = 0;          col[2] = 0;       end
            1: begin col[0] = 1 << 30; col[1] = -(1 << 28); col[2] = 1 << 27; end
            2: begin col[0] = -1;      col[1] = -1;         col[2] = -1;      end
            3: begin col[0] = 32'sh8000_0000; col[1] = 32'sh8000_0000; col[2] = 32'sh8000_0000; end
            default: begin
                for (int i = 0; i < 3; i++) begin
                    col[i] = int'($urandom);
                    if ($urandom_range(1, 0) == 1) col[i] = col[i] >>> $urandom_range(20, 0);
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int kind, input int gaps, input int bp_cycles);
        longint e [3][3];
        int col [3];
        int accepted = 0;
        int cyc = 0;
        int early = 0;
        int lat = 0;
        int rdy_hi = 0;
        longint g, v;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) e[i][j] = 0;
        while (accepted < N_SAMPLES && cyc < 4000) begin
            if (out_valid) early = 1;
            gen_col(kind, col);
            for (int i = 0; i < 3; i++) u_in[i] = col[i];
            in_valid = (gaps != 0) ? ($urandom_range(2, 0) != 0) : 1'b1;
            if (in_valid && in_ready) begin
                accepted++;
                for (int i = 0; i < 3; i++) begin
                    g = clamp(q14(longint'(col[i])), -16384, 16384);
                    for (int j = 0; j < 3; j++) begin
                        v = clamp(q14(longint'(col[j])), -32768, 32767);
                        e[i][j] += g * v;
                    end
                end
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("accepts", accepted, N_SAMPLES);
        check("early_valid", early, 0);
        check("drain_rdy", in_ready, 0);
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check("latency", lat, 2);
        in_valid = 1'b1;
        for (int c = 0; c < bp_cycles; c++) begin
            if (in_ready) rdy_hi++;
            step();
        end
        in_valid = 1'b0;
        check("bp_rdy", rdy_hi, 0);
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("k%0d_g%0d%0d", kind, i, j), g_acc[i][j], e[i][j]);
        case (kind)
            0: check("id_g00", g_acc[0][0], 64'sd17179869184);
            1: begin
                check("sat_g00", g_acc[0][0], 64'sd34358689792);
                check("sat_g10", g_acc[1][0], -64'sd34358689792);
                check("sat_g21", g_acc[2][1], -64'sd8589934592);
                check("sat_g11", g_acc[1][1], 64'sd17179869184);
            end
            2: check("bub_g22", g_acc[2][2], 64);
            3: check("neg_g01", g_acc[0][1], 64'sd34359738368);
            default: ;
        endcase
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("rel_valid", out_valid, 0);
        check("rel_rdy", in_ready, 1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("clr_g%0d%0d", i, j), g_acc[i][j], 0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) u_in[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_rdy", in_ready, 1);
        check("rst_valid", out_valid, 0);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("rst_g%0d%0d", i, j), g_acc[i][j], 0);

        run_frame(0, 0, 0);
        run_frame(1, 0, 0);
        run_frame(0, 0, 20);
        run_frame(2, 1, 0);

        for (int i = 0; i < 3; i++) u_in[i] = (i == 0) ? (1 << 28) : 0;
        in_valid = 1'b1;
        repeat (30) step();
        in_valid = 1'b0;
        reset    = 1'b0;
        step();
        reset = 1'b1;
        check("mid_rst_g00", g_acc[0][0], 0);
        check("mid_rst_rdy", in_ready, 1);
        run_frame(0, 0, 0);

        run_frame(3, 1, 0);
        run_frame(4, 1, 5);
        run_frame(4, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ica_gu_accum.md
Name: ica_gu_accum

Overview:
- Stage directly downstream of the 64-column W*x unmixing array.
- Consumes the unmixed outputs u, one 3-element column per handshake.
- For each column, applies the ICA hard-tanh nonlinearity g(u) and accumulates the 3x3 matrix G = sum over k of g(u[:,k]) * v[:,k]^T, where v is u rescaled to Q14.
- After N_SAMPLES columns, presents G to the weight-update stage via valid/ready, then re-arms for the next frame.

Parameters:
- FRAC, 14: fractional shift taking Q28 products back to Q14.
- N_SAMPLES, 64: columns per frame.
- ACC_W, 40: accumulator width. Worst case is 2^29 per product times 64 = 2^35, so no overflow is possible.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- u_in[0:2]  in  32 signed each  one column of u (Q28)
- in_valid  in  1  column valid
- in_ready  out  1  block accepts a column this cycle
- g_acc[0:2][0:2]  out  ACC_W signed each  G[i][j]
- out_valid  out  1  G complete and stable
- out_ready  in  1  consumer takes G

Behaviour:
- Reset: one clock and one reset; reset is synchronous, active-low (reset==0 sampled at a clk edge).
  - On reset: state=ACCUM, cnt=0, all g_acc=0, out_valid=0, pipeline valid bits=0, in_ready=1 from the first cycle after reset.
  - A reset mid-frame or during OUT discards all partial sums; there is no output.
- Scaling: s_i = u_in[i] >>> FRAC (arithmetic, floor).
  - v_i = s_i saturated to [-32768, 32767].
  - g_i = s_i saturated to [-16384, +16384] (hard-tanh, ±1.0 in Q14).
- Pipeline:
  - Accept edge t: register g[0:2] and v[0:2] with a valid bit (stage 1).
  - Edge t+1: all nine products g_i*v_j are formed as 32-bit signed, sign-extended to ACC_W and added to g_acc[i][j] (stage 2).
  - Throughput is 1 column/cycle.
- Accepting a column: accepted = in_valid & in_ready. The counter cnt (0..N_SAMPLES-1) increments on each accept.
- State machine: states ACCUM, DRAIN, OUT.
  - ACCUM: in_ready=1. When the accept with cnt==N_SAMPLES-1 occurs, cnt returns to 0 and the next state is DRAIN.
  - DRAIN: in_ready=0. Waits until stage 1 and stage 2 are empty (the last accumulate lands), then moves to OUT. Minimum 2 cycles after the final accept; out_valid rises on the 2nd edge after that accept.
  - OUT: out_valid=1, in_ready=0, g_acc held stable.
    - While out_ready=0: hold indefinitely.
    - When out_ready=1: at that edge clear g_acc to 0, out_valid goes to 0, return to ACCUM. in_ready=1 in the following cycle.
- in_valid while in_ready=0: ignored; the column is not consumed and is not counted.
- Output timing: g_acc is registered. Its value in ACCUM and DRAIN is the partial sum, but it is defined only when out_valid=1.
- Gaps: idle cycles (in_valid=0) inside a frame do not disturb the count or the sums.
- No saturation is applied on g_acc; the ACC_W bound guarantees exactness.

Decomposition:
- ica_pkg holds:
  - constants FRAC, N_SAMPLES, ACC_W, U_W=32, Q_W=16, G_ONE=16384;
  - the state enum {ACCUM, DRAIN, OUT};
  - a typedef for the 3x3 accumulator array.
- One natural sub-module: ica_hardtanh, a combinational block taking u (32-bit) to g (16-bit) and v (16-bit). It performs shift plus both saturations and is instantiated 3 times.
- The MAC array and FSM stay in the top module.

Test Plan:
- Identity frame: 64 columns u=(2^28, 0, 0) with in_valid held high -> g=v=(16384, 0, 0).
  - Expect g_acc[0][0]=64*2^28=17179869184 and all others 0.
  - out_valid asserts exactly 2 cycles after the 64th accept.
- Saturation and sign: 64 columns u=(2^30, -2^28, 2^27).
  - Expect g=(16384, -16384, 8192) and v=(32767, -16384, 8192).
  - g_acc[0][0]=64*16384*32767, g_acc[1][0]=-64*16384*32767, g_acc[2][1]=-64*8192*16384, g_acc[1][1]=64*2^28.
- Backpressure: hold out_ready=0 for 20 cycles with in_valid=1.
  - Expect in_ready=0, g_acc stable, no columns counted.
  - Release out_ready: g_acc clears, and the next frame sums only its own 64 columns.
- Bubbles: insert random in_valid=0 gaps, 64 accepted columns u=(-1, -1, -1).
  - s=-1, so g=v=-1 and every g_acc[i][j]=64.
  - out_valid does not rise before the 64th accept.
- Reset mid-frame: reset=0 for 1 cycle after 30 accepts, then a full 64-column identity frame.
  - Expect the result equal to the identity case, with no contribution from the first 30.
- Extreme negative: u=-2^31 for all three lanes.
  - Expect g=-16384, v=-32768 and each g_acc=64*16384*32768=2^35, with no overflow.
